mc_array_ctrl: RTL and testbench
================================

MC_ARRAY_CTRL -- requirements
Module: mc_array_ctrl

Interface
REQ-001 SHALL have parameter: PULSE_CYCLES, 4, program/arm pulse width in clocks, legal range 1..255.
REQ-002 SHALL have these ports; the clock is clk_i and the reset is rst_ni, asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  1  0=read, 1=write
- cmd_row_i  in  6  target row 0..63
- cmd_wdata_i  in  64  write bit per column
- cmd_wmask_i  in  64  1=column participates in write
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  64  read data; 0 for writes
- rsp_err_o  out  1  write-verify mismatch
- CWLE  out  32  odd-row word lines
- CWLO  out  32  even-row word lines
- CBLEN  out  64  bit-line enable per column
- CBL  out  64  bit-line drive
- CSL  out  64  source-line drive
- DIN  out  64  read drive
- DINb  out  64  read drive complement
- DOUT  in  64  array read data

Function
REQ-003 SHALL drive row r: even r asserts CWLO[r/2]; odd r asserts CWLE[r/2]; at most one word-line bit high at any time.
REQ-004 SHALL assert cmd_ready_o only in IDLE; on cmd_valid_i&cmd_ready_o, latch op/row/wdata/wmask and leave IDLE next cycle.
REQ-005 SHALL implement states IDLE, SETUP, PROG_A, GAP, PROG_B, RD_ARM, RD_EVAL, RD_SAMPLE, RELEASE, RESP, with an 8-bit pulse counter.
REQ-006 SETUP (1 cycle): word line high; CBLEN, CBL, CSL = 0; write->PROG_A, read->RD_ARM.
REQ-007 PROG_A (PULSE_CYCLES): CBLEN=m, CBL=~d&m, CSL=d&m (d=wdata, m=wmask); ->GAP.
REQ-008 GAP (1 cycle): CBLEN, CBL, CSL = 0; ->PROG_B (or ->RD_ARM after PROG_B, verify build only).
REQ-009 PROG_B (PULSE_CYCLES): CBLEN=m, CBL=~d&m, CSL=~d&m; ->RELEASE (->GAP in verify build).
REQ-010 RD_ARM (PULSE_CYCLES): CBLEN=0, CSL=all ones; ->RD_EVAL (1 cycle, CSL=0); ->RD_SAMPLE (1 cycle), which captures ~DOUT into the read register at cycle end.
REQ-011 DIN SHALL be all ones and DINb all zeros in RD_ARM, RD_EVAL and RD_SAMPLE; both SHALL be 0 otherwise.
REQ-012 RELEASE (1 cycle): all array outputs 0; ->RESP.
REQ-013 RESP: rsp_valid_o=1, with rsp_data_o/rsp_err_o stable until rsp_ready_i; the handshake cycle ->IDLE. A new command is accepted no earlier than the following cycle.
REQ-014 Latency from the accept edge to the first rsp_valid_o cycle SHALL be P+5 cycles for reads and 2P+4 cycles for writes (P=PULSE_CYCLES).
REQ-015 An all-zero wmask SHALL still run the full write sequence with CBLEN=0 throughout; rsp_err_o=0.
REQ-016 rsp_data_o SHALL be 0 for write responses.

Reset
REQ-017 SHALL, while rst_ni=0, force IDLE and drive all outputs to 0 (cmd_ready_o included) asynchronously, including mid-pulse.
REQ-018 SHALL raise cmd_ready_o on the first clk_i edge after rst_ni deasserts.

Configuration
REQ-019 With MC_CTRL_VERIFY_EN defined, each write SHALL continue PROG_B->GAP->RD_ARM->RD_EVAL->RD_SAMPLE->RELEASE->RESP; rsp_err_o = |((~DOUT ^ d) & m) from RD_SAMPLE; write latency 3P+7.
REQ-020 Without MC_CTRL_VERIFY_EN, rsp_err_o SHALL be tied 0 and the write path SHALL match REQ-009.

Verification
REQ-021 P=4: write row 5, wdata=0xA5A5..A5, mask all ones -> only CWLE[2] high; PROG_A CSL=0xA5A5.., PROG_B CSL=0x5A5A..; rsp_valid_o at cycle 12.
REQ-022 Read row 5 after REQ-021 -> only CWLE[2] high; rsp_data_o=0xA5A5..A5 at cycle 9.
REQ-023 Write row 0, mask=0x0000_0000_FFFF_FFFF, then read -> upper 32 bits keep their prior values; CBLEN upper half stays 0 throughout the write.
REQ-024 Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0; release -> IDLE next cycle.
REQ-025 Assert rst_ni=0 during PROG_B -> all array outputs 0 immediately; after release, read returns consistent data without hang.
REQ-026 MC_CTRL_VERIFY_EN: force DOUT bit 3 wrong during RD_SAMPLE -> rsp_err_o=1 at cycle 19; correct DOUT -> rsp_err_o=0.

Source files
------------

// File: rtl/mc_array_ctrl.sv
// Command-driven sequencer for a 64x64 resistive array: decodes one row, sequences program pulses or a
// read sample, and returns a handshaked response. Define MC_CTRL_VERIFY_EN to add a read-back check to each write.
module mc_array_ctrl #(
  parameter int unsigned PULSE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [5:0]  cmd_row_i,
  input  logic [63:0] cmd_wdata_i,
  input  logic [63:0] cmd_wmask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [31:0] CWLE,
  output logic [31:0] CWLO,
  output logic [63:0] CBLEN,
  output logic [63:0] CBL,
  output logic [63:0] CSL,
  output logic [63:0] DIN,
  output logic [63:0] DINb,
  input  logic [63:0] DOUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PROG_A, S_GAP, S_PROG_B,
    S_RD_ARM, S_RD_EVAL, S_RD_SAMPLE, S_RELEASE, S_RESP
  } state_e;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        live_q;
  logic        op_q;
  logic [5:0]  row_q;
  logic [63:0] wdata_q, wmask_q, rdata_q;
  logic        accept, wl_on;

  // live_q keeps cmd_ready_o low during reset and lets it rise on the first edge afterwards
  assign cmd_ready_o = live_q && (state_q == S_IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = (state_q == S_RESP && !op_q) ? rdata_q : 64'd0;
  assign DINb        = 64'd0;
  assign wl_on       = state_q inside {S_SETUP, S_PROG_A, S_GAP, S_PROG_B,
                                       S_RD_ARM, S_RD_EVAL, S_RD_SAMPLE};

`ifdef MC_CTRL_VERIFY_EN
  logic progb_done_q;
  logic err_q;
  assign rsp_err_o = (state_q == S_RESP) && err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      progb_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        progb_done_q <= 1'b0;
      end else if (state_q == S_PROG_B && cnt_q == 8'd0) begin
        progb_done_q <= 1'b1;
      end
      if (state_q == S_RD_SAMPLE) begin
        err_q <= op_q && (|((~DOUT ^ wdata_q) & wmask_q));
      end
    end
  end
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      live_q  <= 1'b0;
      op_q    <= 1'b0;
      row_q   <= 6'd0;
      wdata_q <= 64'd0;
      wmask_q <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      if (accept) begin
        op_q    <= cmd_op_i;
        row_q   <= cmd_row_i;
        wdata_q <= cmd_wdata_i;
        wmask_q <= cmd_wmask_i;
      end
      // Cells read back inverted on DOUT
      if (state_q == S_RD_SAMPLE) begin
        rdata_q <= ~DOUT;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP: begin
        state_d = op_q ? S_PROG_A : S_RD_ARM;
        cnt_d   = PULSE_LAST;
      end
      S_PROG_A: begin
        if (cnt_q == 8'd0) state_d = S_GAP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_GAP: begin
        cnt_d = PULSE_LAST;
`ifdef MC_CTRL_VERIFY_EN
        state_d = progb_done_q ? S_RD_ARM : S_PROG_B;
`else
        state_d = S_PROG_B;
`endif
      end
      S_PROG_B: begin
        if (cnt_q == 8'd0) begin
`ifdef MC_CTRL_VERIFY_EN
          state_d = S_GAP;
`else
          state_d = S_RELEASE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RD_ARM: begin
        if (cnt_q == 8'd0) state_d = S_RD_EVAL;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_RD_EVAL:   state_d = S_RD_SAMPLE;
      S_RD_SAMPLE: state_d = S_RELEASE;
      S_RELEASE:   state_d = S_RESP;
      S_RESP:      if (rsp_ready_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Even rows sit on CWLO, odd rows on CWLE; only one line is ever raised
  always_comb begin
    CWLE  = 32'd0;
    CWLO  = 32'd0;
    CBLEN = 64'd0;
    CBL   = 64'd0;
    CSL   = 64'd0;
    DIN   = 64'd0;
    if (wl_on) begin
      if (row_q[0]) CWLE[row_q[5:1]] = 1'b1;
      else          CWLO[row_q[5:1]] = 1'b1;
    end
    case (state_q)
      S_PROG_A: begin
        CBLEN = wmask_q;
        CBL   = ~wdata_q & wmask_q;
        CSL   = wdata_q & wmask_q;
      end
      S_PROG_B: begin
        CBLEN = wmask_q;
        CBL   = ~wdata_q & wmask_q;
        CSL   = ~wdata_q & wmask_q;
      end
      S_RD_ARM: begin
        CSL = '1;
        DIN = '1;
      end
      S_RD_EVAL, S_RD_SAMPLE: DIN = '1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Randomized bench for mc_array_ctrl: a behavioural resistive-array model answers the pins, and a
// plain memory model predicts read data. Compile with MC_CTRL_VERIFY_EN to match the verify build.
module tb_mc_array_ctrl;

  localparam int P = 4;
`ifdef MC_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int PH_SETUP = 0, PH_PA = 1, PH_GAP = 2, PH_PB = 3, PH_ARM = 4,
                 PH_EVAL = 5, PH_SAMPLE = 6, PH_RELEASE = 7, PH_RESP = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_op_i = 1'b0;
  logic [5:0]  cmd_row_i = '0;
  logic [63:0] cmd_wdata_i = '0;
  logic [63:0] cmd_wmask_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic [31:0] CWLE, CWLO;
  logic [63:0] CBLEN, CBL, CSL, DIN, DINb, DOUT;

  int checks = 0;
  int errors = 0;

  logic [63:0] cells   [64];
  logic [63:0] seedMem [64];
  logic [63:0] refMem  [64];
  logic        loadArray = 1'b1;
  logic [63:0] doutFlip = '0;
  int          dSel;

  mc_array_ctrl #(.PULSE_CYCLES(P)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_row_i(cmd_row_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wmask_i(cmd_wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o), .CWLE(CWLE), .CWLO(CWLO), .CBLEN(CBLEN), .CBL(CBL),
    .CSL(CSL), .DIN(DIN), .DINb(DINb), .DOUT(DOUT)
  );

  always #5 clk_i = ~clk_i;

  function automatic int selRow(input logic [31:0] wle, input logic [31:0] wlo);
    int r = -1;
    for (int i = 0; i < 32; i++) begin
      if (wlo[i]) r = 2 * i;
      if (wle[i]) r = 2 * i + 1;
    end
    return r;
  endfunction

  // Array physics: set where SL drives alone, reset where BL drives alone; read returns inverted cells
  always_comb begin
    DOUT = '0;
    dSel = selRow(CWLE, CWLO);
    if (dSel >= 0 && DIN == '1) DOUT = ~cells[dSel] ^ doutFlip;
  end

  always @(negedge clk_i) begin
    automatic int r = selRow(CWLE, CWLO);
    automatic logic [63:0] setB = CBLEN & CSL & ~CBL;
    automatic logic [63:0] clrB = CBLEN & CBL & ~CSL;
    if (loadArray) begin
      for (int i = 0; i < 64; i++) cells[i] <= seedMem[i];
    end else if (r >= 0) begin
      cells[r] <= (cells[r] | setB) & ~clrB;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int phaseAt(input logic op, input int n);
    if (n == 1) return PH_SETUP;
    if (!op) begin
      if (n <= P + 1) return PH_ARM;
      if (n == P + 2) return PH_EVAL;
      if (n == P + 3) return PH_SAMPLE;
      if (n == P + 4) return PH_RELEASE;
      return PH_RESP;
    end
    if (n <= P + 1)     return PH_PA;
    if (n == P + 2)     return PH_GAP;
    if (n <= 2 * P + 2) return PH_PB;
    if (!VERIFY) return (n == 2 * P + 3) ? PH_RELEASE : PH_RESP;
    if (n == 2 * P + 3) return PH_GAP;
    if (n <= 3 * P + 3) return PH_ARM;
    if (n == 3 * P + 4) return PH_EVAL;
    if (n == 3 * P + 5) return PH_SAMPLE;
    if (n == 3 * P + 6) return PH_RELEASE;
    return PH_RESP;
  endfunction

  function automatic logic [63:0] wlVec(input logic [5:0] row);
    logic [63:0] v = '0;
    int idx = row[0] ? 32 + int'(row[5:1]) : int'(row[5:1]);
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " wl"}, {CWLE, CWLO}, '0);
    checkOutput({tag, " cblen"}, CBLEN, '0);
    checkOutput({tag, " cbl"}, CBL, '0);
    checkOutput({tag, " csl"}, CSL, '0);
    checkOutput({tag, " din"}, DIN, '0);
    checkOutput({tag, " dinb"}, DINb, '0);
    checkOutput({tag, " ctl"}, {61'd0, cmd_ready_o, rsp_valid_o, rsp_err_o}, '0);
    checkOutput({tag, " rdata"}, rsp_data_o, '0);
  endtask

  task automatic sendCmd(input logic op, input logic [5:0] row, input logic [63:0] d, input logic [63:0] m);
    checkOutput("ready before cmd", {63'd0, cmd_ready_o}, 64'd1);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_row_i = row; cmd_wdata_i = d; cmd_wmask_i = m;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_op_i = $urandom_range(0, 1); cmd_row_i = 6'($urandom);
    cmd_wdata_i = {$urandom, $urandom}; cmd_wmask_i = {$urandom, $urandom};
  endtask

  task automatic checkPins(input logic op, input int n, input logic [5:0] row,
                           input logic [63:0] d, input logic [63:0] m);
    int ph = phaseAt(op, n);
    logic [63:0] eWl = (ph <= PH_SAMPLE) ? wlVec(row) : 64'd0;
    logic [63:0] eCblen = (ph == PH_PA || ph == PH_PB) ? m : 64'd0;
    logic [63:0] eCbl = (ph == PH_PA || ph == PH_PB) ? (~d & m) : 64'd0;
    logic [63:0] eCsl = (ph == PH_PA) ? (d & m) : (ph == PH_PB) ? (~d & m) :
                        (ph == PH_ARM) ? '1 : 64'd0;
    logic [63:0] eDin = (ph == PH_ARM || ph == PH_EVAL || ph == PH_SAMPLE) ? '1 : 64'd0;
    checkOutput("wordline", {CWLE, CWLO}, eWl);
    checkOutput("cblen", CBLEN, eCblen);
    checkOutput("cbl", CBL, eCbl);
    checkOutput("csl", CSL, eCsl);
    checkOutput("din", DIN, eDin);
    checkOutput("dinb", DINb, '0);
    checkOutput("busy ready", {63'd0, cmd_ready_o}, '0);
    checkOutput("rsp_valid timing", {63'd0, rsp_valid_o}, {63'd0, ph == PH_RESP});
  endtask

  task automatic applyStimulus(input logic op, input logic [5:0] row, input logic [63:0] d,
                               input logic [63:0] m, input int hold);
    int lat = !op ? P + 5 : (VERIFY ? 3 * P + 7 : 2 * P + 4);
    logic [63:0] expData = op ? 64'd0 : refMem[row];
    logic expErr = op && VERIFY && (|(doutFlip & m));
    if (op) refMem[row] = (refMem[row] & ~m) | (d & m);
    rsp_ready_i = 1'b0;
    sendCmd(op, row, d, m);
    for (int n = 1; n <= lat; n++) begin
      checkPins(op, n, row, d, m);
      if (n < lat) begin
        @(posedge clk_i); #1;
      end
    end
    checkOutput("rsp_data", rsp_data_o, expData);
    checkOutput("rsp_err", {63'd0, rsp_err_o}, {63'd0, expErr});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      checkOutput("hold valid", {63'd0, rsp_valid_o}, 64'd1);
      checkOutput("hold data", rsp_data_o, expData);
      checkOutput("hold err", {63'd0, rsp_err_o}, {63'd0, expErr});
      checkOutput("hold ready", {63'd0, cmd_ready_o}, 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    checkOutput("post-hs valid", {63'd0, rsp_valid_o}, 64'd0);
    checkOutput("post-hs ready", {63'd0, cmd_ready_o}, 64'd1);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    #1 checkOutput("ready before first edge", {63'd0, cmd_ready_o}, 64'd0);
    @(posedge clk_i); #1;
    checkOutput("ready after reset", {63'd0, cmd_ready_o}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      seedMem[i] = {$urandom, $urandom};
      refMem[i]  = seedMem[i];
    end
    repeat (3) @(posedge clk_i);
    #1 checkAllZero("in reset");
    loadArray = 1'b0;
    releaseReset();

    applyStimulus(1'b1, 6'd5, {8{8'hA5}}, '1, 0);
    applyStimulus(1'b0, 6'd5, '0, '0, 0);
    applyStimulus(1'b1, 6'd0, {$urandom, $urandom}, 64'h0000_0000_FFFF_FFFF, 1);
    applyStimulus(1'b0, 6'd0, '0, '0, 0);
    applyStimulus(1'b0, 6'd63, '0, '0, 10);
    applyStimulus(1'b1, 6'd62, {$urandom, $urandom}, '0, 2);
    applyStimulus(1'b0, 6'd62, '0, '0, 0);

    if (VERIFY) begin
      doutFlip = 64'h8;
      applyStimulus(1'b1, 6'd9, {$urandom, $urandom}, '1, 0);
      doutFlip = '0;
      applyStimulus(1'b1, 6'd9, {$urandom, $urandom}, '1, 0);
    end

    for (int t = 0; t < 30; t++) begin
      automatic logic op = 1'($urandom_range(0, 1));
      automatic logic [5:0] row = 6'($urandom);
      automatic int mk = $urandom_range(0, 3);
      automatic logic [63:0] m = (mk == 0) ? 64'd0 : (mk == 1) ? '1 : {$urandom, $urandom};
      applyStimulus(op, row, {$urandom, $urandom}, m, $urandom_range(0, 3));
    end

    // Abort a write in its second pulse; the first pulse has already committed the data
    begin
      automatic logic [63:0] d = {$urandom, $urandom};
      sendCmd(1'b1, 6'd17, d, '1);
      for (int n = 1; n < P + 4; n++) begin
        @(posedge clk_i); #1;
      end
      #2 rst_ni = 1'b0;
      #1 checkAllZero("abort");
      refMem[17] = d;
      releaseReset();
      applyStimulus(1'b0, 6'd17, '0, '0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
